hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core, a parametrised successor to the existing combinational hazard unit. It generates Execute- and Decode-stage forwarding selects, load-use and branch stalls, and a Execute flush. It also tracks a variable-latency multiply/divide unit with a small state machine, so Decode stalls any HI/LO consumer until the unit has retired.

## Interface
Parameters:
- REG_W, 5, register-specifier width.
- MD_LATENCY, 32, cycles the multiply/divide unit stays busy (≥1).
- CNT_W, 32, width of the stall performance counter (used only with HAZARD_PERF_EN).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- branch_d  in  1  Decode holds a branch that compares in Decode.
- rs_d, rt_d  in  REG_W  Decode source registers.
- rs_e, rt_e  in  REG_W  Execute source registers.
- writereg_e, writereg_m, writereg_w  in  REG_W  destination register per stage.
- regwrite_e, regwrite_m, regwrite_w  in  1  stage writes the register file.
- memtoreg_e, memtoreg_m  in  1  stage holds a load.
- md_start_e  in  1  multiply/divide issued from Execute this cycle.
- mdread_d  in  1  Decode instruction reads HI/LO or issues a new multiply/divide.
- stallF, stallD, flushE  out  1  pipeline control.
- forwardAD, forwardBD  out  1  Decode forward from Memory.
- forwardAE, forwardBE  out  2  Execute forward select.
- md_busy  out  1  multiply/divide in flight.
- md_done  out  1  one-cycle pulse on the final busy cycle.
- stall_count  out  CNT_W  stall cycles since reset (with HAZARD_PERF_EN only).

## Operation
Register 0 never matches in any comparison.

**Execute forwarding (A and B symmetric)**
- Select 2'b10 if the source matches writereg_m and regwrite_m is high.
- Otherwise select 2'b01 if it matches writereg_w and regwrite_w is high.
- Otherwise select 2'b00.
- The Memory stage has priority over Writeback.

**Decode forwarding**
- forwardAD = rs_d≠0 && rs_d==writereg_m && regwrite_m.
- forwardBD is the same with rt_d.

**lwstall**
- memtoreg_e && rt_e≠0 && (rs_d==rt_e || rt_d==rt_e).

**branchstall**
- branch_d && ((regwrite_e && writereg_e≠0 && writereg_e∈{rs_d,rt_d}) || (memtoreg_m && writereg_m≠0 && writereg_m∈{rs_d,rt_d})).

**mdstall**
- mdread_d && (md_start_e || state≠IDLE).

**Pipeline control**
- stallF = stallD = flushE = lwstall | branchstall | mdstall.

**Multiply/divide state machine**
- IDLE: on md_start_e, load cnt=MD_LATENCY-1 and go to BUSY.
- BUSY: if cnt==0, go to DONE; otherwise decrement cnt.
- DONE: go to IDLE. If md_start_e is high, restart directly into BUSY.
- md_busy = (state≠IDLE).
- md_done = (state==BUSY && cnt==0).
- md_start_e while in BUSY is illegal: it is ignored and flagged by a simulation assertion.

## Timing
- All forwarding and stall outputs are combinational from the inputs and the current state. They have zero latency.
- Reset values: state=IDLE, cnt=0, md_busy=0, md_done=0, stall_count=0.
- With reset held and no hazard inputs asserted, all stall/flush/forward outputs are 0.
- Multiply/divide timeline for md_start_e at edge k:
  - BUSY for MD_LATENCY cycles, then DONE for one cycle, then IDLE.
  - A waiting mdread_d is released in the first IDLE cycle, MD_LATENCY+1 cycles after the first busy cycle.
- Reset in the middle of an operation forces IDLE the next edge. The in-flight operation is abandoned and md_done is not produced.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_count increments each cycle stallD is 1 and saturates at all-ones.
  - It clears on reset.
- Not defined:
  - The stall_count port and counter are absent.

## Structure
- Shared package hazard_pkg holds:
  - fwd_sel_t (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - md_state_t (IDLE, BUSY, DONE).
  - Default REG_W.
- The multiply/divide state machine and counter live in sub-module md_tracker, which outputs md_busy, md_done and the pending indication.
- Forwarding and stall logic stay in hazard_ctrl.

## Test plan
- Forwarding priority: rs_e=5, writereg_m=5/regwrite_m=1 and writereg_w=5/regwrite_w=1 → forwardAE=10; drop regwrite_m → 01; set rs_e=0 → 00.
- Load-use: memtoreg_e=1, rt_e=8, rs_d=8 → stallF=stallD=flushE=1; rt_e=0 → no stall.
- Branch: branch_d=1, regwrite_e=1, writereg_e=3, rt_d=3 → stall; next, memtoreg_m=1, writereg_m=3 → stall; regwrite_m only → forwardBD=1, no stall.
- Multiply/divide with MD_LATENCY=4: md_start_e at cycle 0, mdread_d held high → md_busy cycles 1–5, md_done at cycle 4, stallD high cycles 0–5 and low at cycle 6.
- Reset mid-operation: reset at cycle 2 of BUSY → md_busy=0 next cycle, md_done never pulses, a waiting mdread_d is released.
- HAZARD_PERF_EN: drive 7 stall cycles → stall_count=7; with CNT_W=3 and 9 stalls → stays at 7.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and defaults for the pipeline hazard controller.
//   fwd_sel_t  : Execute-stage forwarding select encoding.
//   md_state_t : multiply/divide tracker states.
//   fwd_pick   : resolves Memory-over-Writeback forwarding priority.
package hazard_pkg;

    localparam int unsigned DEFAULT_REG_W = 5;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } md_state_t;

    // Memory stage holds the younger result, so it wins over Writeback.
    function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit)
            return FWD_MEM;
        else if (wb_hit)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_tracker.sv
// md_tracker
//   Tracks a variable-latency multiply/divide unit.
//   After md_start_e the unit is BUSY for MD_LATENCY cycles, then DONE for
//   one cycle, then IDLE. A start in DONE restarts straight into BUSY.
//   A start while BUSY is illegal: it is ignored and trips an assertion.
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   md_start_e   : operation issued from Execute this cycle
//   md_busy      : registered, high while not IDLE
//   md_done      : registered, high on the final BUSY cycle
//   md_pending   : high while not IDLE (used by Decode stall logic)
module md_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic md_start_e,
    output logic md_busy,
    output logic md_done,
    output logic md_pending
);

    localparam int unsigned CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(MD_LATENCY - 1);

    md_state_t      state;
    logic [CW-1:0]  cnt;

    // md_busy/md_done are registered, so each branch assigns the value they
    // must show in the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (md_start_e) begin
                        state   <= BUSY;
                        cnt     <= LAST;
                        md_busy <= 1'b1;
                        md_done <= (LAST == '0);
                    end else begin
                        state   <= IDLE;
                        md_busy <= 1'b0;
                        md_done <= 1'b0;
                    end
                end
                BUSY: begin
                    assert (!md_start_e);
                    md_busy <= 1'b1;
                    if (cnt == '0) begin
                        state   <= DONE;
                        md_done <= 1'b0;
                    end else begin
                        cnt     <= cnt - CW'(1);
                        md_done <= (cnt == CW'(1));
                    end
                end
                default: begin
                    state   <= IDLE;
                    cnt     <= '0;
                    md_busy <= 1'b0;
                    md_done <= 1'b0;
                end
            endcase
        end
    end

    assign md_pending = (state != IDLE);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller for the five-stage MIPS core: Execute and
//   Decode forwarding selects, load-use / branch / multiply-divide stalls,
//   and the Execute flush. Forwarding and stall outputs are combinational.
// Configuration
//   HAZARD_PERF_EN : adds parameter CNT_W and port stall_count, a saturating
//                    count of cycles with stallD high, cleared on reset.
// Ports
//   clk, reset                         : clock, synchronous active-high reset
//   branch_d                           : Decode holds a branch
//   rs_d, rt_d, rs_e, rt_e             : source registers
//   writereg_e/m/w, regwrite_e/m/w     : destination and write enable per stage
//   memtoreg_e, memtoreg_m             : stage holds a load
//   md_start_e, mdread_d               : multiply/divide issue / HI-LO consumer
//   stallF, stallD, flushE             : pipeline control
//   forwardAD, forwardBD               : Decode forward from Memory
//   forwardAE, forwardBE               : Execute forward select (fwd_sel_t)
//   md_busy, md_done                   : multiply/divide status
//   stall_count                        : stall cycle counter (HAZARD_PERF_EN)
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W      = DEFAULT_REG_W,
    parameter int unsigned MD_LATENCY = 32
`ifdef HAZARD_PERF_EN
    ,
    parameter int unsigned CNT_W      = 32
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch_d,
    input  logic [REG_W-1:0] rs_d,
    input  logic [REG_W-1:0] rt_d,
    input  logic [REG_W-1:0] rs_e,
    input  logic [REG_W-1:0] rt_e,
    input  logic [REG_W-1:0] writereg_e,
    input  logic [REG_W-1:0] writereg_m,
    input  logic [REG_W-1:0] writereg_w,
    input  logic             regwrite_e,
    input  logic             regwrite_m,
    input  logic             regwrite_w,
    input  logic             memtoreg_e,
    input  logic             memtoreg_m,
    input  logic             md_start_e,
    input  logic             mdread_d,
    output logic             stallF,
    output logic             stallD,
    output logic             flushE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             md_busy,
    output logic             md_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_count
`endif
);

    logic md_pending;
    logic lwstall;
    logic branchstall;
    logic mdstall;
    logic stall;

    md_tracker #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md (
        .clk       (clk),
        .reset     (reset),
        .md_start_e(md_start_e),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .md_pending(md_pending)
    );

    always_comb begin
        forwardAE = fwd_pick((rs_e != '0) && (rs_e == writereg_m) && regwrite_m,
                             (rs_e != '0) && (rs_e == writereg_w) && regwrite_w);
        forwardBE = fwd_pick((rt_e != '0) && (rt_e == writereg_m) && regwrite_m,
                             (rt_e != '0) && (rt_e == writereg_w) && regwrite_w);

        forwardAD = (rs_d != '0) && (rs_d == writereg_m) && regwrite_m;
        forwardBD = (rt_d != '0) && (rt_d == writereg_m) && regwrite_m;

        lwstall = memtoreg_e && (rt_e != '0) && ((rs_d == rt_e) || (rt_d == rt_e));

        // A branch compares in Decode, so it must wait for an ALU result still
        // in Execute or a load still in Memory.
        branchstall = branch_d &&
            ((regwrite_e && (writereg_e != '0) &&
              ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
             (memtoreg_m && (writereg_m != '0) &&
              ((writereg_m == rs_d) || (writereg_m == rt_d))));

        // Covers the issue cycle too, before the tracker has left IDLE.
        mdstall = mdread_d && (md_start_e || md_pending);

        stall  = lwstall || branchstall || mdstall;
        stallF = stall;
        stallD = stall;
        flushE = stall;
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset)
            stall_count <= '0;
        else if (stall && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int unsigned RW  = 5;
    localparam int unsigned LAT = 4;
`ifdef HAZARD_PERF_EN
    localparam int unsigned CW  = 3;
`endif

    logic          clk = 1'b0;
    logic          reset, branch_d, regwrite_e, regwrite_m, regwrite_w;
    logic          memtoreg_e, memtoreg_m, md_start_e, mdread_d;
    logic [RW-1:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic          stallF, stallD, flushE, forwardAD, forwardBD, md_busy, md_done;
    logic [1:0]    forwardAE, forwardBE;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] stall_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state: cycles remaining until the unit is idle again
    // (BUSY cycles plus the DONE cycle); 0 means idle.
    int rem = 0;
    int sc  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_W     (RW),
        .MD_LATENCY(LAT)
`ifdef HAZARD_PERF_EN
        ,
        .CNT_W     (CW)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .branch_d  (branch_d),
        .rs_d      (rs_d),
        .rt_d      (rt_d),
        .rs_e      (rs_e),
        .rt_e      (rt_e),
        .writereg_e(writereg_e),
        .writereg_m(writereg_m),
        .writereg_w(writereg_w),
        .regwrite_e(regwrite_e),
        .regwrite_m(regwrite_m),
        .regwrite_w(regwrite_w),
        .memtoreg_e(memtoreg_e),
        .memtoreg_m(memtoreg_m),
        .md_start_e(md_start_e),
        .mdread_d  (mdread_d),
        .stallF    (stallF),
        .stallD    (stallD),
        .flushE    (flushE),
        .forwardAD (forwardAD),
        .forwardBD (forwardBD),
        .forwardAE (forwardAE),
        .forwardBE (forwardBE),
        .md_busy   (md_busy),
        .md_done   (md_done)
`ifdef HAZARD_PERF_EN
        ,
        .stall_count(stall_count)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input int a, input int b);
        return (a != 0) && (a == b);
    endfunction

    function automatic int exp_fwd_e(input int src);
        if (hit(src, int'(writereg_m)) && regwrite_m) return 2;
        if (hit(src, int'(writereg_w)) && regwrite_w) return 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit lw, br, md;
        lw = memtoreg_e && rt_e != 0 && (rs_d == rt_e || rt_d == rt_e);
        br = branch_d && ((regwrite_e && (hit(int'(writereg_e), int'(rs_d)) || hit(int'(writereg_e), int'(rt_d)))) ||
                          (memtoreg_m && (hit(int'(writereg_m), int'(rs_d)) || hit(int'(writereg_m), int'(rt_d)))));
        md = mdread_d && (md_start_e || rem > 0);
        return lw || br || md;
    endfunction

    task automatic check_all();
        bit s;
        s = exp_stall();
        check_val("forwardAE", 32'(forwardAE), 32'(exp_fwd_e(int'(rs_e))));
        check_val("forwardBE", 32'(forwardBE), 32'(exp_fwd_e(int'(rt_e))));
        check_val("forwardAD", 32'(forwardAD), 32'(hit(int'(rs_d), int'(writereg_m)) && regwrite_m));
        check_val("forwardBD", 32'(forwardBD), 32'(hit(int'(rt_d), int'(writereg_m)) && regwrite_m));
        check_val("stallF", 32'(stallF), 32'(s));
        check_val("stallD", 32'(stallD), 32'(s));
        check_val("flushE", 32'(flushE), 32'(s));
        check_val("md_busy", 32'(md_busy), 32'(rem > 0));
        check_val("md_done", 32'(md_done), 32'(rem == 2));
`ifdef HAZARD_PERF_EN
        check_val("stall_count", 32'(stall_count), 32'(sc));
`endif
    endtask

    // Advance one clock and the reference model with it; inputs stay stable
    // across the edge and are changed only after the next falling edge.
    task automatic tick();
        bit s;
        s = exp_stall();
        @(posedge clk);
        if (reset) begin
            rem = 0;
            sc  = 0;
        end else begin
            if (md_start_e && rem <= 1) rem = LAT + 1;
            else if (rem > 0)           rem = rem - 1;
`ifdef HAZARD_PERF_EN
            if (s && sc < (1 << CW) - 1) sc = sc + 1;
`endif
        end
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {branch_d, regwrite_e, regwrite_m, regwrite_w} = '0;
        {memtoreg_e, memtoreg_m, md_start_e, mdread_d} = '0;
        {rs_d, rt_d, rs_e, rt_e} = '0;
        {writereg_e, writereg_m, writereg_w} = '0;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_val("rst_stallD", 32'(stallD), 32'd0);
        check_val("rst_fwdAE", 32'(forwardAE), 32'd0);
        tick();
        check_val("rst_md_busy", 32'(md_busy), 32'd0);
        check_val("rst_md_done", 32'(md_done), 32'd0);
        check_all();
        reset = 1'b0;
        tick();

        // Execute forwarding priority.
        rs_e = 5; writereg_m = 5; regwrite_m = 1; writereg_w = 5; regwrite_w = 1;
        #1 check_val("fwd_mem_prio", 32'(forwardAE), 32'd2);
        regwrite_m = 0;
        #1 check_val("fwd_wb", 32'(forwardAE), 32'd1);
        rs_e = 0;
        #1 check_val("fwd_r0", 32'(forwardAE), 32'd0);
        clear_inputs();

        // Load-use.
        memtoreg_e = 1; rt_e = 8; rs_d = 8;
        #1 check_val("lw_stallF", 32'(stallF), 32'd1);
        check_val("lw_flushE", 32'(flushE), 32'd1);
        rt_e = 0;
        #1 check_val("lw_r0", 32'(stallD), 32'd0);
        clear_inputs();

        // Branch compare in Decode.
        branch_d = 1; regwrite_e = 1; writereg_e = 3; rt_d = 3;
        #1 check_val("br_alu", 32'(stallD), 32'd1);
        regwrite_e = 0; memtoreg_m = 1; writereg_m = 3;
        #1 check_val("br_load", 32'(stallD), 32'd1);
        memtoreg_m = 0; regwrite_m = 1;
        #1 check_val("br_fwdBD", 32'(forwardBD), 32'd1);
        check_val("br_nostall", 32'(stallD), 32'd0);
        clear_inputs();
        tick();

        // Multiply/divide timeline: start at cycle 0, consumer waiting.
        md_start_e = 1; mdread_d = 1;
        #1 check_val("md_c0_stall", 32'(stallD), 32'd1);
        tick();
        md_start_e = 0;
        for (int c = 1; c <= 6; c++) begin
            check_val("md_tl_busy", 32'(md_busy), 32'(c >= 1 && c <= 5));
            check_val("md_tl_done", 32'(md_done), 32'(c == 4));
            check_val("md_tl_stall", 32'(stallD), 32'(c <= 5));
            check_all();
            tick();
        end

        // Reset during BUSY abandons the operation.
        md_start_e = 1;
        tick();
        md_start_e = 0;
        tick();
        reset = 1;
        tick();
        reset = 0;
        for (int c = 0; c < 6; c++) begin
            check_val("rst_mid_busy", 32'(md_busy), 32'd0);
            check_val("rst_mid_done", 32'(md_done), 32'd0);
            check_val("rst_mid_stall", 32'(stallD), 32'd0);
            tick();
        end
        clear_inputs();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 59) == 0);
            branch_d   = $urandom_range(0, 3) == 0;
            regwrite_e = $urandom_range(0, 1) == 1;
            regwrite_m = $urandom_range(0, 1) == 1;
            regwrite_w = $urandom_range(0, 1) == 1;
            memtoreg_e = $urandom_range(0, 3) == 0;
            memtoreg_m = $urandom_range(0, 3) == 0;
            mdread_d   = $urandom_range(0, 2) == 0;
            md_start_e = (rem <= 1) && ($urandom_range(0, 5) == 0);
            rs_d       = RW'($urandom_range(0, 5));
            rt_d       = RW'($urandom_range(0, 5));
            rs_e       = RW'($urandom_range(0, 5));
            rt_e       = RW'($urandom_range(0, 5));
            writereg_e = RW'($urandom_range(0, 5));
            writereg_m = RW'($urandom_range(0, 5));
            writereg_w = RW'($urandom_range(0, 5));
            #1;
            check_all();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
